// File: rtl/color_classify_filt.sv
// ---------------------------------------------------------------------------
// color_classify_filt
//   Box-averages 2^AVG_LOG2 RGB samples per channel, classifies each average
//   into one of 8 colour codes and debounces the code before it is presented
//   to the LED / menu logic.
//
// Ports
//   sys_clk, sys_rst_n : clock (rising edge), async active-low reset
//   clr                : synchronous restart of window / debounce state
//   in_valid, in_r/g/b : one-cycle sample strobe and channel samples
//   avg_r/g/b          : last completed window average
//   avg_valid          : one-cycle pulse when avg_* update
//   class_out          : debounced code {b_on,g_on,r_on}
//   class_chg          : one-cycle pulse when class_out changes
//
// Timing: last sample of a window at edge E -> avg_* / avg_valid after E,
// classification and class_out update after E+1.
// ---------------------------------------------------------------------------
module color_classify_filt #(
    parameter int DW       = 8,
    parameter int AVG_LOG2 = 2,
    parameter int STABLE_N = 3,
    parameter int DARK_TH  = 32
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] avg_r,
    output logic [DW-1:0] avg_g,
    output logic [DW-1:0] avg_b,
    output logic          avg_valid,
    output logic [2:0]    class_out,
    output logic          class_chg
);

    localparam int AW = DW + AVG_LOG2;
    // Keep the sample counter at least 1 bit wide so AVG_LOG2 = 0 stays legal.
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [3:0]    STAB = 4'(STABLE_N);
    localparam logic [DW-1:0] DARK = DW'(DARK_TH);

    // Channel index 0 = red, 1 = green, 2 = blue (matches code bit order).
    logic [2:0][DW-1:0] smp;
    logic [2:0][AW-1:0] acc_q, acc_d, sum;
    logic [2:0][DW-1:0] avg_q, avg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               avgv_q, avgv_d;
    logic               last_smp;

    logic [DW-1:0]      mx;
    logic [2:0]         cand;
    logic [2:0]         cand_q, cand_d;
    logic [3:0]         stab_q, stab_d;
    logic [2:0]         cls_q, cls_d;
    logic               chg_q, chg_d;

    assign smp = {in_b, in_g, in_r};

    generate
        if (AVG_LOG2 == 0) begin : g_noavg
            assign last_smp = 1'b1;
        end else begin : g_avg
            assign last_smp = &cnt_q;
        end
    endgenerate

    // ---------------- accumulate / average ----------------
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum[c] = acc_q[c] + AW'(smp[c]);
        end
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        avg_d  = avg_q;
        avgv_d = 1'b0;
        if (clr) begin
            // clr wins over a coincident sample; that sample is dropped.
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            if (last_smp) begin
                // Window closes: divide the completed sums and start fresh
                // in the same cycle so back-to-back samples are never lost.
                acc_d = '0;
                cnt_d = '0;
                for (int c = 0; c < 3; c++) begin
                    avg_d[c] = DW'(sum[c] >> AVG_LOG2);
                end
                avgv_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // ---------------- classify ----------------
    always_comb begin
        mx = avg_q[0];
        if (avg_q[1] > mx) mx = avg_q[1];
        if (avg_q[2] > mx) mx = avg_q[2];
        cand = '0;
        if (mx >= DARK) begin
            // 2*avg >= max, evaluated at DW+1 bits so the doubling cannot wrap.
            for (int c = 0; c < 3; c++) begin
                cand[c] = ({avg_q[c], 1'b0} >= {1'b0, mx});
            end
        end
    end

    // ---------------- debounce ----------------
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        cls_d  = cls_q;
        chg_d  = 1'b0;
        if (clr) begin
            cand_d = '0;
            stab_d = '0;
        end else if (avgv_q) begin
            if (cand == cand_q) begin
                stab_d = (stab_q >= STAB) ? STAB : stab_q + 4'd1;
            end else begin
                stab_d = 4'd1;
                cand_d = cand;
            end
            if (stab_d >= STAB && cand != cls_q) begin
                cls_d = cand;
                chg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            avg_q  <= '0;
            avgv_q <= 1'b0;
            cand_q <= '0;
            stab_q <= '0;
            cls_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            avg_q  <= avg_d;
            avgv_q <= avgv_d;
            cand_q <= cand_d;
            stab_q <= stab_d;
            cls_q  <= cls_d;
            chg_q  <= chg_d;
        end
    end

    assign avg_r     = avg_q[0];
    assign avg_g     = avg_q[1];
    assign avg_b     = avg_q[2];
    assign avg_valid = avgv_q;
    assign class_out = cls_q;
    assign class_chg = chg_q;

endmodule

// File: tb/tb_color_classify_filt.sv
// ---------------------------------------------------------------------------
// tb_color_classify_filt
//   Directed stimulus against color_classify_filt (default parameters).
//   A queue-based behavioural model predicts every output each cycle; a
//   compare process checks them on the falling edge, and literal checks at
//   key points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_color_classify_filt;

    localparam int N   = 4;   // samples per window (AVG_LOG2 = 2)
    localparam int SN  = 3;   // STABLE_N
    localparam int DTH = 32;  // DARK_TH

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic [7:0] avg_r, avg_g, avg_b;
    logic       avg_valid;
    logic [2:0] class_out;
    logic       class_chg;

    color_classify_filt #(.DW(8), .AVG_LOG2(2), .STABLE_N(SN), .DARK_TH(DTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .avg_r     (avg_r),
        .avg_g     (avg_g),
        .avg_b     (avg_b),
        .avg_valid (avg_valid),
        .class_out (class_out),
        .class_chg (class_chg)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int qr[$], qg[$], qb[$];
    int m_avg[3];
    bit m_avgv, m_chg;
    int m_cls, m_prev, m_run;

    function automatic int classify(input int r, input int g, input int b);
        int mx, code;
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        if (mx < DTH) return 0;
        code = 0;
        if (2 * r >= mx) code += 1;
        if (2 * g >= mx) code += 2;
        if (2 * b >= mx) code += 4;
        return code;
    endfunction

    function automatic int qsum(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    initial begin : model
        bit nchg, navgv;
        int c;
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                qr.delete(); qg.delete(); qb.delete();
                m_avg = '{0, 0, 0};
                m_avgv = 0; m_chg = 0; m_cls = 0; m_prev = 0; m_run = 0;
            end else begin
                nchg = 0;
                navgv = 0;
                // classification of the average published last cycle
                if (m_avgv && !clr) begin
                    c = classify(m_avg[0], m_avg[1], m_avg[2]);
                    if (c == m_prev) m_run++;
                    else begin
                        m_run = 1;
                        m_prev = c;
                    end
                    if (m_run >= SN && c != m_cls) begin
                        m_cls = c;
                        nchg = 1;
                    end
                end
                if (clr) begin
                    qr.delete(); qg.delete(); qb.delete();
                    m_run = 0;
                    m_prev = 0;
                end else if (in_valid) begin
                    qr.push_back(int'(in_r));
                    qg.push_back(int'(in_g));
                    qb.push_back(int'(in_b));
                    if (qr.size() == N) begin
                        m_avg[0] = qsum(qr) / N;
                        m_avg[1] = qsum(qg) / N;
                        m_avg[2] = qsum(qb) / N;
                        navgv = 1;
                        qr.delete(); qg.delete(); qb.delete();
                    end
                end
                m_avgv = navgv;
                m_chg = nchg;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge sys_clk);
            chk("avg_valid", int'(avg_valid), int'(m_avgv));
            chk("avg_r", int'(avg_r), m_avg[0]);
            chk("avg_g", int'(avg_g), m_avg[1]);
            chk("avg_b", int'(avg_b), m_avg[2]);
            chk("class_out", int'(class_out), m_cls);
            chk("class_chg", int'(class_chg), int'(m_chg));
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 2 time units after a rising edge and are held through
    // the next rising edge.
    task automatic cyc(input bit v, input int r, input int g, input int b, input bit c = 1'b0);
        in_valid = v;
        in_r = 8'(r);
        in_g = 8'(g);
        in_b = 8'(b);
        clr = c;
        @(posedge sys_clk);
        #2;
        in_valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic win(input int r, input int g, input int b);
        repeat (N) cyc(1, r, g, b);
    endtask

    // Three identical windows; class_out must switch to exp after the third.
    task automatic win3(input string nm, input int r, input int g, input int b, input int exp);
        repeat (3) begin
            win(r, g, b);
            cyc(0, 0, 0, 0);
        end
        chk({nm, "_class"}, int'(class_out), exp);
        chk({nm, "_chg"}, int'(class_chg), 1);
    endtask

    int dbr[6] = '{200, 200, 10, 200, 200, 200};
    int dbg[6] = '{10, 10, 200, 10, 10, 10};
    int pulses;

    initial begin : stim
        repeat (2) @(posedge sys_clk);
        #2;
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_avg_r", int'(avg_r), 0);
        chk("rst_class", int'(class_out), 0);
        chk("rst_chg", int'(class_chg), 0);
        sys_rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // basic red window, three times
        win(200, 10, 10);
        chk("w1_avgv", int'(avg_valid), 1);
        chk("w1_avg_r", int'(avg_r), 200);
        chk("w1_avg_g", int'(avg_g), 10);
        chk("w1_avg_b", int'(avg_b), 10);
        cyc(0, 0, 0, 0);
        chk("w1_class", int'(class_out), 0);
        chk("w1_chg", int'(class_chg), 0);
        win(200, 10, 10);
        cyc(0, 0, 0, 0);
        chk("w2_class", int'(class_out), 0);
        win(200, 10, 10);
        cyc(0, 0, 0, 0);
        chk("w3_class", int'(class_out), 1);
        chk("w3_chg", int'(class_chg), 1);

        // truncating average and full-scale average
        cyc(1, 100, 10, 10);
        cyc(1, 101, 10, 10);
        cyc(1, 102, 10, 10);
        cyc(1, 103, 10, 10);
        chk("trunc_avg_r", int'(avg_r), 101);
        cyc(0, 0, 0, 0);
        win(255, 0, 0);
        chk("full_avg_r", int'(avg_r), 255);
        cyc(0, 0, 0, 0);

        // threshold boundaries
        win3("dark31", 31, 5, 31, 0);
        win3("yellow", 200, 100, 10, 3);
        win3("red99", 200, 99, 10, 1);
        win3("white", 40, 40, 40, 7);

        // debounce: red, red, green, red, red, red
        for (int i = 0; i < 6; i++) begin
            win(dbr[i], dbg[i], 10);
            cyc(0, 0, 0, 0);
            chk("deb_class", int'(class_out), (i < 5) ? 7 : 1);
            chk("deb_chg", int'(class_chg), (i < 5) ? 0 : 1);
        end

        // continuous strobe for 12 cycles
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 8 * i, 20, 30);
            if (avg_valid) pulses++;
            chk("stream_avgv", int'(avg_valid), (i % 4 == 0) ? 1 : 0);
            if (i == 12) chk("stream_avg_r", int'(avg_r), 84);
        end
        cyc(0, 0, 0, 0);
        chk("stream_pulses", pulses, 3);

        // clr coincident with the 3rd sample
        cyc(1, 1, 1, 1);
        cyc(1, 2, 2, 2);
        cyc(1, 3, 3, 3, 1'b1);
        cyc(1, 60, 0, 0);
        cyc(1, 64, 0, 0);
        cyc(1, 68, 0, 0);
        chk("clr_no_early", int'(avg_valid), 0);
        cyc(1, 72, 0, 0);
        chk("clr_avgv", int'(avg_valid), 1);
        chk("clr_avg_r", int'(avg_r), 66);
        cyc(0, 0, 0, 0);
        chk("pre_rst_class", int'(class_out), 1);

        // asynchronous reset mid-window
        cyc(1, 50, 50, 50);
        cyc(1, 50, 50, 50);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("arst_class", int'(class_out), 0);
        chk("arst_avg_r", int'(avg_r), 0);
        chk("arst_avgv", int'(avg_valid), 0);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        win(90, 90, 90);
        chk("post_rst_avgv", int'(avg_valid), 1);
        chk("post_rst_avg_r", int'(avg_r), 90);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/color_classify_filt.md
Name: color_classify_filt

Overview:
- Sits between the colour-sensor front end and the WS2812 LED driver.
- Takes raw per-channel colour samples with a valid strobe and box-averages 2^AVG_LOG2 samples per channel.
- Classifies each average into one of 8 colour codes.
- Debounces the code so that only a stable colour change reaches the LED and menu logic.

Parameters:
- DW, 8, width of each colour channel sample.
- AVG_LOG2, 2, log2 of samples averaged per result (0..6); 0 means no averaging.
- STABLE_N, 3, consecutive identical candidate codes required before class_out changes (1..15).
- DARK_TH, 32, a max channel below this value classifies as black (DW bits).

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous restart: flushes accumulators, sample count and stability counter.
- in_valid  input  1  one-cycle strobe; in_r/g/b are sampled when high.
- in_r  input  DW  red sample.
- in_g  input  DW  green sample.
- in_b  input  DW  blue sample.
- avg_r  output  DW  averaged red.
- avg_g  output  DW  averaged green.
- avg_b  output  DW  averaged blue.
- avg_valid  output  1  one-cycle pulse when avg_* update.
- class_out  output  3  debounced colour code {b_on,g_on,r_on}: 0 black, 1 red, 2 green, 3 yellow, 4 blue, 5 magenta, 6 cyan, 7 white.
- class_chg  output  1  one-cycle pulse when class_out changes.

Behaviour:
- Reset: all outputs 0, so class_out = black.
  - Accumulators, sample counter (AVG_LOG2 bits), candidate register, stability counter and pipeline flags are 0.
- Accumulation:
  - Three accumulators, each DW+AVG_LOG2 bits wide, so they cannot overflow.
  - On in_valid, each accumulator adds its sample and the sample counter increments.
  - On the 2^AVG_LOG2-th sample (counter wraps to 0), the accumulators load 0 in the same cycle. No sample is lost; the next in_valid starts a fresh window.
  - The completed sums are latched for the divide stage.
- Average stage: the cycle after the final sample, avg_x = sum_x >> AVG_LOG2 (truncating) and avg_valid = 1 for one cycle. Latency is 1 cycle from the last accepted sample.
- Classify stage: the cycle after avg_valid, from the registered averages:
  - mx = max(avg_r, avg_g, avg_b).
  - If mx < DARK_TH, the candidate code is 0.
  - Otherwise each channel's bit is set when 2*avg_x >= mx. Compare at DW+1 bits with no overflow.
- Stability counter: 4-bit, saturating at STABLE_N, evaluated in the classify cycle.
  - If the candidate equals the previous candidate, the counter increments. If it differs, the counter loads 1 and the previous candidate is updated.
  - When the post-update count is >= STABLE_N and the candidate != class_out, class_out loads the candidate in that same cycle and class_chg pulses that cycle.
  - Total latency from the final sample to class_out: 2 cycles.
  - If the candidate equals class_out, there is no pulse.
- clr:
  - Zeroes the accumulators, sample counter, stability counter, candidate and pending avg/classify flags.
  - class_out and avg_* hold their values.
  - clr has priority over a simultaneous in_valid, and that sample is discarded.
- An in_valid during the average or classify stages is accepted normally into the new window. The pipeline is fully overlapped with no back-pressure, so a sample strobe every cycle is supported.
- Asynchronous reset mid-window discards the partial window; the first post-reset result needs 2^AVG_LOG2 fresh samples.

Test Plan:
- Reset, then 4 samples of (200,10,10) with defaults -> avg_valid one cycle after the 4th with avg = 200,10,10; classify/debounce count = 1. After the 3rd identical window, class_out = 1 (red) and class_chg pulses, 2 cycles after that window's last sample.
- Samples 100,101,102,103 on red -> avg_r = 101 (sum 406 >> 2). Samples 255 x4 -> avg_r = 255 with no overflow.
- Threshold cases: mx = 31, any mix -> black. (200,100,10) -> 2*100 >= 200, yellow = 3. (200,99,10) -> red = 1. (40,40,40) -> white = 7.
- Debounce: windows red, red, green, red, red, red (STABLE_N = 3) -> class_out changes to red only after the final window. The green window resets the counter, and there is no pulse for green.
- in_valid held high for 12 consecutive cycles -> exactly 3 avg_valid pulses at the 4th, 8th and 12th sample +1 cycle. No dropped sample.
- clr asserted together with the 3rd sample of a window -> that sample is discarded, and 4 further samples are required before the next avg_valid.
- Reset pulse mid-window -> outputs 0 immediately and asynchronously.
